// File: rtl/uart_rx_frame_parser_if.sv
`timescale 1ns/1ps
// Byte stream from the UART receiver plus the payload read handshake towards user logic.
// The parser sits on the slave side; whoever feeds bytes and pops payload uses master.
interface uart_rx_frame_parser_if;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       rd_en;
  logic [7:0] pl_data;
  logic       pl_valid;
  logic [4:0] pl_len;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic [7:0] drop_cnt;
  logic       busy;

  modport master (
    output rx_data, rx_rdy, rd_en,
    input  pl_data, pl_valid, pl_len, frame_ok, frame_err, err_code, drop_cnt, busy
  );

  modport slave (
    input  rx_data, rx_rdy, rd_en,
    output pl_data, pl_valid, pl_len, frame_ok, frame_err, err_code, drop_cnt, busy
  );
endinterface

// File: rtl/uart_rx_frame_parser.sv
`timescale 1ns/1ps
// Parses SOF/LEN/payload/CHK frames from a UART byte stream, buffers the payload
// and hands it out one byte per read strobe; bad length, checksum or stalls raise an error code.
module uart_rx_frame_parser #(
  parameter int         MAX_LEN = 16,
  parameter int         TIMEOUT = 104160,
  parameter logic [7:0] SOF     = 8'hAA
) (
  input logic                   clk,
  input logic                   rst,
  uart_rx_frame_parser_if.slave bus
);
  localparam int PW = $clog2(MAX_LEN) + 1;
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, CHK, HOLD} state_t;

  state_t        state_reg, state_next;
  logic [7:0]    mem [MAX_LEN];
  logic [7:0]    rd_q;
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0] rd_addr;
  logic [7:0]    sum_reg;
  logic [4:0]    pl_len_reg;
  logic [7:0]    drop_cnt_reg;
  logic [16:0]   tmo_cnt_reg;
  logic          frame_ok_reg, frame_err_reg;
  logic [1:0]    err_code_reg;

  logic counting, timed_out, len_bad, chk_good, pop, last_pop;
  logic ok_set, err_set, in_hold, not_idle;
  logic [1:0] err_val;

  assign counting  = (state_reg == LEN) || (state_reg == PAYLOAD) || (state_reg == CHK);
  // A byte arriving on the terminal count wins over the timeout.
  assign timed_out = counting && !bus.rx_rdy && (tmo_cnt_reg == 17'(TIMEOUT - 1));
  assign len_bad   = (bus.rx_data == 8'd0) || (int'(bus.rx_data) > MAX_LEN);
  assign chk_good  = (bus.rx_data == sum_reg);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (timed_out) begin
      state_next = IDLE;
    end else begin
      unique case (state_reg)
        IDLE:    if (bus.rx_rdy && bus.rx_data == SOF) state_next = LEN;
        LEN:     if (bus.rx_rdy) state_next = len_bad ? IDLE : PAYLOAD;
        PAYLOAD: if (bus.rx_rdy && (wr_ptr_reg + PW'(1) == PW'(pl_len_reg))) state_next = CHK;
        CHK:     if (bus.rx_rdy) state_next = chk_good ? HOLD : IDLE;
        HOLD:    if (last_pop) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    ok_set   = 1'b0;
    err_set  = 1'b0;
    err_val  = 2'd0;
    in_hold  = (state_reg == HOLD);
    not_idle = (state_reg != IDLE);
    pop      = in_hold && bus.rd_en;
    last_pop = pop && (rd_ptr_reg == PW'(pl_len_reg) - PW'(1));
    if (timed_out) begin
      err_set = 1'b1;
      err_val = 2'd3;
    end else if (bus.rx_rdy) begin
      if (state_reg == LEN && len_bad) begin
        err_set = 1'b1;
        err_val = 2'd1;
      end
      if (state_reg == CHK) begin
        ok_set  = chk_good;
        err_set = !chk_good;
        err_val = 2'd2;
      end
    end
  end

  // Read pointer restarts at 0 whenever the block is outside HOLD.
  assign rd_ptr_next = !in_hold ? '0 : (pop ? rd_ptr_reg + PW'(1) : rd_ptr_reg);
  // After the final pop the address may wrap; that read is never presented.
  assign rd_addr     = rd_ptr_next[AW-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      sum_reg       <= 8'd0;
      pl_len_reg    <= 5'd0;
      drop_cnt_reg  <= 8'd0;
      tmo_cnt_reg   <= 17'd0;
      frame_ok_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      err_code_reg  <= 2'd0;
    end else begin
      frame_ok_reg  <= ok_set;
      frame_err_reg <= err_set;
      if (err_set) err_code_reg <= err_val;
      if (bus.rx_rdy && state_reg == LEN && !len_bad) begin
        pl_len_reg <= bus.rx_data[4:0];
        sum_reg    <= bus.rx_data;
        wr_ptr_reg <= '0;
      end else if (bus.rx_rdy && state_reg == PAYLOAD) begin
        sum_reg    <= sum_reg + bus.rx_data;
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      rd_ptr_reg <= rd_ptr_next;
      if (bus.rx_rdy && in_hold && drop_cnt_reg != 8'hFF) drop_cnt_reg <= drop_cnt_reg + 8'd1;
      if (bus.rx_rdy || !counting) tmo_cnt_reg <= 17'd0;
      else                         tmo_cnt_reg <= tmo_cnt_reg + 17'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.rx_rdy && state_reg == PAYLOAD) mem[wr_ptr_reg[AW-1:0]] <= bus.rx_data;
    rd_q <= mem[rd_addr];
  end

  assign bus.pl_data   = in_hold ? rd_q : 8'd0;
  assign bus.pl_valid  = in_hold;
  assign bus.pl_len    = pl_len_reg;
  assign bus.frame_ok  = frame_ok_reg;
  assign bus.frame_err = frame_err_reg;
  assign bus.err_code  = err_code_reg;
  assign bus.drop_cnt  = drop_cnt_reg;
  assign bus.busy      = not_idle;
endmodule

// File: tb/tb_uart_rx_frame_parser.sv
`timescale 1ns/1ps
// Directed and randomised frames for uart_rx_frame_parser, compared every cycle
// against a queue-based frame model.
module tb_uart_rx_frame_parser;
  localparam int         MAX_LEN = 16;
  localparam int         TIMEOUT = 100;
  localparam logic [7:0] SOF     = 8'hAA;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_rx_frame_parser_if bus();
  uart_rx_frame_parser #(.MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT), .SOF(SOF)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Model: bytes collected since SOF, and payload waiting to be read.
  byte unsigned col[$];
  byte unsigned held[$];
  int silent;
  bit exp_ok, exp_err;
  int exp_code, exp_len, exp_drop;
  int rd_mode;

  int ok_seen = 0, err_seen = 0, last_code_seen = 0, err_edge = 0, last_rdy_edge = 0;
  byte unsigned pops[$];

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    col.delete(); held.delete();
    silent = 0; exp_ok = 0; exp_err = 0;
    exp_code = 0; exp_len = 0; exp_drop = 0;
  endtask

  task automatic raise_err(int code);
    exp_err  = 1;
    exp_code = code;
  endtask

  task automatic frame_rules();
    int n, len, s;
    n   = col.size();
    len = col[1];
    if (n == 2) begin
      if (len == 0 || len > MAX_LEN) begin col.delete(); raise_err(1); end
      else exp_len = len;
    end else if (n == len + 3) begin
      s = 0;
      for (int i = 1; i < n - 1; i++) s += col[i];
      if ((s % 256) == int'(col[n-1])) begin
        held.delete();
        for (int i = 2; i < n - 1; i++) held.push_back(col[i]);
        exp_ok = 1;
      end else begin
        raise_err(2);
      end
      col.delete();
    end
  endtask

  task automatic model_step(bit rdy, byte unsigned d, bit rd);
    exp_ok  = 0;
    exp_err = 0;
    if (held.size() > 0) begin
      if (rd) void'(held.pop_front());
      if (rdy && exp_drop < 255) exp_drop++;
    end else if (col.size() > 0) begin
      if (rdy) begin
        silent = 0;
        col.push_back(d);
        frame_rules();
      end else begin
        silent++;
        if (silent >= TIMEOUT) begin col.delete(); raise_err(3); end
      end
    end else if (rdy && d == SOF) begin
      col.push_back(d);
      silent = 0;
    end
  endtask

  always @(negedge clk) begin
    check("frame_ok",  int'(bus.frame_ok),  int'(exp_ok));
    check("frame_err", int'(bus.frame_err), int'(exp_err));
    check("err_code",  int'(bus.err_code),  exp_code);
    check("pl_valid",  int'(bus.pl_valid),  int'(held.size() > 0));
    if (held.size() > 0) check("pl_data", int'(bus.pl_data), int'(held[0]));
    check("pl_len",    int'(bus.pl_len),    exp_len);
    check("drop_cnt",  int'(bus.drop_cnt),  exp_drop);
    check("busy",      int'(bus.busy),      int'(col.size() > 0 || held.size() > 0));
    if (bus.frame_ok) begin
      ok_seen++;
      $display("[%0t] frame_ok  len=%0d", $time, bus.pl_len);
    end
    if (bus.frame_err) begin
      err_seen++;
      last_code_seen = int'(bus.err_code);
      err_edge = edge_cnt;
      $display("[%0t] frame_err code=%0d", $time, bus.err_code);
    end
    if (rst && bus.pl_valid && bus.rd_en) pops.push_back(bus.pl_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rst) begin
      if (bus.rx_rdy) last_rdy_edge = edge_cnt;
      model_step(bus.rx_rdy, bus.rx_data, bus.rd_en);
    end
    case (rd_mode)
      0:       bus.rd_en = 1'b0;
      1:       bus.rd_en = 1'b1;
      default: bus.rd_en = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic send(byte unsigned b, int gap);
    bus.rx_data = b;
    bus.rx_rdy  = 1'b1;
    tick();
    bus.rx_rdy  = 1'b0;
    bus.rx_data = 8'($urandom);
    repeat (gap) tick();
  endtask

  task automatic send_all(input byte unsigned s[$], input int gap);
    foreach (s[i]) send(s[i], gap);
  endtask

  task automatic check_pops(string name, input byte unsigned want[$]);
    check({name, "_count"}, pops.size(), want.size());
    foreach (want[i]) check(name, (i < pops.size()) ? int'(pops[i]) : -1, int'(want[i]));
  endtask

  initial begin
    byte unsigned seq[$];
    byte unsigned want[$];
    int ok0, err0, kind, len, s;
    byte unsigned b;

    rst = 1'b0;
    bus.rx_rdy = 1'b0; bus.rx_data = 8'd0; bus.rd_en = 1'b0;
    rd_mode = 0;
    model_reset();
    repeat (3) tick();
    check("rst_busy", int'(bus.busy), 0);
    check("rst_pl_valid", int'(bus.pl_valid), 0);
    check("rst_drop_cnt", int'(bus.drop_cnt), 0);
    rst = 1'b1;
    repeat (2) tick();

    // Good frame with rd_en held high
    rd_mode = 1; ok0 = ok_seen; pops.delete();
    seq = '{8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    send_all(seq, 0);
    repeat (6) tick();
    check("good_ok_pulses", ok_seen - ok0, 1);
    want = '{8'h11, 8'h22, 8'h33}; check_pops("good_pop", want);
    check("good_pl_len", int'(bus.pl_len), 3);
    check("good_idle", int'(bus.busy), 0);

    // Bad checksum, then a good frame
    ok0 = ok_seen; err0 = err_seen;
    seq = '{8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h68};
    send_all(seq, 0);
    repeat (3) tick();
    check("badchk_err", err_seen - err0, 1);
    check("badchk_code", last_code_seen, 2);
    check("badchk_no_ok", ok_seen - ok0, 0);
    pops.delete();
    seq = '{8'hAA, 8'h02, 8'h01, 8'h02, 8'h05};
    send_all(seq, 1);
    repeat (5) tick();
    check("after_badchk_ok", ok_seen - ok0, 1);
    want = '{8'h01, 8'h02}; check_pops("after_badchk_pop", want);

    // Bad LEN and preamble
    err0 = err_seen;
    seq = '{8'hAA, 8'h00}; send_all(seq, 0);
    repeat (3) tick();
    check("len0_err", err_seen - err0, 1);
    check("len0_code", last_code_seen, 1);
    seq = '{8'hAA, 8'h11}; send_all(seq, 0);
    repeat (3) tick();
    check("len17_err", err_seen - err0, 2);
    check("len17_code", last_code_seen, 1);
    ok0 = ok_seen; pops.delete();
    seq = '{8'h55, 8'hAA, 8'h01, 8'h7E, 8'h7F}; send_all(seq, 0);
    repeat (4) tick();
    check("preamble_ok", ok_seen - ok0, 1);
    want = '{8'h7E}; check_pops("preamble_pop", want);

    // Timeout and the terminal-count boundary
    err0 = err_seen;
    seq = '{8'hAA, 8'h02, 8'h11}; send_all(seq, 0);
    repeat (120) tick();
    check("tmo_err", err_seen - err0, 1);
    check("tmo_code", last_code_seen, 3);
    check("tmo_latency", err_edge - last_rdy_edge, 100);
    ok0 = ok_seen; err0 = err_seen; pops.delete();
    send(8'hAA, 0); send(8'h02, 0); send(8'h11, 99); send(8'h22, 99); send(8'h35, 0);
    repeat (5) tick();
    check("tmo_edge_ok", ok_seen - ok0, 1);
    check("tmo_edge_no_err", err_seen - err0, 0);
    want = '{8'h11, 8'h22}; check_pops("tmo_edge_pop", want);

    // Hold overflow
    rd_mode = 0; pops.delete();
    seq = '{8'hAA, 8'h02, 8'hA1, 8'hB2, 8'h55}; send_all(seq, 0);
    seq = '{8'hAA, 8'h01, 8'h05, 8'h05}; send_all(seq, 1);
    repeat (3) tick();
    check("hold_drop_cnt", int'(bus.drop_cnt), 4);
    check("hold_pl_data", int'(bus.pl_data), 'hA1);
    rd_mode = 1;
    repeat (5) tick();
    want = '{8'hA1, 8'hB2}; check_pops("hold_pop", want);
    check("hold_idle", int'(bus.busy), 0);

    // Reset mid-frame
    rd_mode = 0;
    seq = '{8'hAA, 8'h04, 8'h01}; send_all(seq, 0);
    #2 rst = 1'b0; model_reset();
    #1;
    check("amid_busy", int'(bus.busy), 0);
    check("amid_pl_len", int'(bus.pl_len), 0);
    check("amid_drop_cnt", int'(bus.drop_cnt), 0);
    check("amid_err_code", int'(bus.err_code), 0);
    check("amid_pl_valid", int'(bus.pl_valid), 0);
    repeat (3) tick();
    rst = 1'b1;
    rd_mode = 1; ok0 = ok_seen; pops.delete();
    seq = '{8'hAA, 8'h01, 8'h09, 8'h0A}; send_all(seq, 0);
    repeat (4) tick();
    check("post_rst_ok", ok_seen - ok0, 1);
    want = '{8'h09}; check_pops("post_rst_pop", want);

    // Randomised traffic against the model
    rd_mode = 2;
    for (int f = 0; f < 200; f++) begin
      seq.delete();
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, MAX_LEN);
      if (kind <= 6 || kind == 9) begin
        seq.push_back(SOF); seq.push_back(8'(len)); s = len;
        for (int i = 0; i < len; i++) begin
          b = 8'($urandom); seq.push_back(b); s += b;
        end
        if (kind == 6) seq.push_back(8'(s) ^ 8'($urandom_range(1, 255)));
        else if (kind <= 5) seq.push_back(8'(s));
        else while (int'(seq.size()) > 2 + $urandom_range(0, len - 1)) void'(seq.pop_back());
      end else if (kind == 7) begin
        seq.push_back(SOF);
        seq.push_back(($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(MAX_LEN + 1, 255)));
      end else begin
        repeat ($urandom_range(1, 4)) seq.push_back(8'($urandom));
      end
      foreach (seq[i])
        send(seq[i], ($urandom_range(0, 19) == 0) ? $urandom_range(97, 101) : $urandom_range(0, 2));
      if (kind == 9) repeat ($urandom_range(100, 103)) tick();
      repeat ($urandom_range(0, 20)) tick();
    end
    rd_mode = 1;
    repeat (200) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_frame_parser.md
Name: uart_rx_frame_parser

Overview:
Sits directly downstream of the UART receiver and consumes its byte stream, presented as an 8-bit data bus plus a one-clock ready pulse per byte. It parses framed packets with the layout SOF(0xAA), LEN, LEN payload bytes, CHK, and stores the payload in an internal buffer. It validates each frame and exposes the payload to user logic through a valid/read handshake. Malformed, corrupted or stalled frames are reported with an error code.

Parameters:
MAX_LEN, 16, maximum payload length in bytes; LEN in 1..MAX_LEN is legal.
TIMEOUT, 104160, inter-byte timeout in clk cycles (2 byte times at 5208 clk/bit, 10 bits/byte).
SOF, 8'hAA, start-of-frame byte.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous reset, active low
rx_data  in  8  received byte from UART receiver, valid when rx_rdy=1
rx_rdy  in  1  one-cycle pulse per received byte
rd_en  in  1  consumer read strobe; pops one payload byte when pl_valid=1
pl_data  out  8  payload byte at the current read pointer
pl_valid  out  1  payload byte available
pl_len  out  5  LEN of the frame currently held
frame_ok  out  1  one-cycle pulse: good frame accepted
frame_err  out  1  one-cycle pulse: frame rejected
err_code  out  2  1=bad LEN, 2=checksum mismatch, 3=timeout; held until next frame_err
drop_cnt  out  8  saturating count of bytes discarded while in HOLD
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE. All outputs are 0, including pl_data, pl_len, err_code and drop_cnt. Buffer contents are don't-care. Reset mid-frame or mid-drain abandons the frame with no pulse.
- Byte processing occurs only in cycles where rx_rdy=1. rx_data is sampled in that same cycle.
- State IDLE: a byte equal to SOF goes to LEN. Any other byte is ignored.
- State LEN:
  - If byte is 0 or greater than MAX_LEN: go to IDLE; frame_err=1 and err_code=1 on the next cycle.
  - Otherwise: latch pl_len=byte, sum=byte, wr_ptr=0, then go to PAYLOAD.
- State PAYLOAD: store buf[wr_ptr]=byte; sum=sum+byte (mod 256); wr_ptr++. When wr_ptr reaches pl_len, go to CHK. SOF-valued bytes are treated as ordinary data.
- State CHK:
  - If byte==sum: go to HOLD and pulse frame_ok.
  - Else: go to IDLE with frame_err=1 and err_code=2.
  - frame_ok or frame_err is asserted in the cycle after the rx_rdy that carried CHK.
- State HOLD:
  - pl_valid=1 and pl_data=buf[rd_ptr], with rd_ptr starting at 0.
  - pl_valid rises in the same cycle as frame_ok.
  - rd_en with pl_valid=1 increments rd_ptr; pl_data updates the next cycle.
  - The rd_en that pops byte pl_len-1 returns the block to IDLE; pl_valid=0 from the next cycle.
  - rd_en while pl_valid=0 is ignored.
- Drops in HOLD: every rx_rdy in HOLD is discarded, including SOF. drop_cnt increments and saturates at 255. drop_cnt is cleared only by reset.
- Timeout:
  - A counter is enabled only in LEN, PAYLOAD and CHK. It clears on every rx_rdy and on entry to LEN.
  - When TIMEOUT consecutive clocks pass without rx_rdy, go to IDLE; frame_err=1 and err_code=3.
  - If rx_rdy coincides with the terminal count, the byte wins and the counter clears.
- Pulse rules:
  - frame_ok and frame_err are never high together. Each lasts exactly one clk.
  - err_code updates in the same cycle as its frame_err.
- pl_len is held from LEN acceptance until the next LEN acceptance.
- Width rules: wr_ptr and rd_ptr are sized by clog2(MAX_LEN)+1. sum is 8-bit wrap-around. The timeout counter is 17 bits.

Test Plan:
- Good frame: bytes AA 03 11 22 33 69, then rd_en held high. Required: frame_ok one pulse; pl_len=3; pl_data 11,22,33 on consecutive cycles; pl_valid drops after the 3rd pop; busy=0.
- Bad checksum: AA 03 11 22 33 68. Required: frame_err pulse with err_code=2, no frame_ok, pl_valid stays 0. A following good frame parses normally.
- Bad LEN, two cases:
  - AA 00: frame_err with err_code=1.
  - AA 11 (17, with MAX_LEN=16): frame_err with err_code=1.
  - Preamble 55 AA 01 7E 7F: the 55 is ignored and the frame is accepted with pl_data=7E.
- Timeout (TIMEOUT=100 in bench): AA 02 11, then silence. Required: frame_err with err_code=3 exactly 100 clk after the last rx_rdy. Also, an rx_rdy landing on cycle 100 is accepted and no error occurs.
- Hold overflow: a good 2-byte frame with no rd_en, then bytes AA 01 05 05 arrive. Required: drop_cnt=4 and the held payload is unchanged. After both pops the block is in IDLE.
- Reset mid-frame: rst low after AA 04 01. Required: all outputs 0 immediately. After release, AA 01 09 0A yields frame_ok and pl_data=09.
